// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, reset/interrupt vector loads, one/two-word instruction assembly.
// Optional interrupt entry is compiled in with `define FETCH_INT_EN.
module fetch_unit #(
  parameter int DATA_W     = 8,
  parameter int RESET_VEC  = 0,
  parameter int INT_VEC    = 1,
  parameter int LONG_MASK  = 'hF0,
  parameter int LONG_MATCH = 'hC0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_addr,
  input  logic              int_req,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] imm,
  output logic              ir_valid,
  output logic              ir_long,
  output logic [DATA_W-1:0] pc_out,
  output logic              int_ack,
  output logic [DATA_W-1:0] ret_pc
);

  localparam logic [1:0] S_RVEC = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_IMM  = 2'd2;
`ifdef FETCH_INT_EN
  localparam logic [1:0] S_IVEC = 2'd3;
`endif

  localparam logic [DATA_W-1:0] L_RVEC  = DATA_W'(RESET_VEC);
  localparam logic [DATA_W-1:0] L_IVEC  = DATA_W'(INT_VEC);
  localparam logic [DATA_W-1:0] L_MASK  = DATA_W'(LONG_MASK);
  localparam logic [DATA_W-1:0] L_MATCH = DATA_W'(LONG_MATCH);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_op;
  logic              r_ir_valid;
  logic              r_ir_long;
  logic              w_is_long;
  logic              w_int_take;

  assign w_is_long = (i_data & L_MASK) == L_MATCH;

  always_comb begin
    i_addr = r_pc;
    if (r_state == S_RVEC) i_addr = L_RVEC;
`ifdef FETCH_INT_EN
    if (r_state == S_IVEC) i_addr = L_IVEC;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_RVEC;
      r_pc       <= '0;
      r_ir       <= '0;
      r_imm      <= '0;
      r_op       <= '0;
      r_ir_valid <= 1'b0;
      r_ir_long  <= 1'b0;
    end else if (r_state == S_RVEC) begin
      r_pc    <= i_data;
      r_state <= S_RUN;
    end else if (redirect) begin
      // Redirect wins everywhere else and drops any half-built two-word instruction.
      r_pc       <= redirect_addr;
      r_ir_valid <= 1'b0;
      r_state    <= S_RUN;
    end else if (!stall) begin
      case (r_state)
        S_RUN: begin
          if (w_int_take) begin
            r_ir_valid <= 1'b0;
`ifdef FETCH_INT_EN
            r_state    <= S_IVEC;
`endif
          end else if (w_is_long) begin
            r_op       <= i_data;
            r_ir_valid <= 1'b0;
            r_pc       <= r_pc + DATA_W'(1);
            r_state    <= S_IMM;
          end else begin
            r_ir       <= i_data;
            r_ir_long  <= 1'b0;
            r_ir_valid <= 1'b1;
            r_pc       <= r_pc + DATA_W'(1);
          end
        end
        S_IMM: begin
          r_ir       <= r_op;
          r_imm      <= i_data;
          r_ir_long  <= 1'b1;
          r_ir_valid <= 1'b1;
          r_pc       <= r_pc + DATA_W'(1);
          r_state    <= S_RUN;
        end
`ifdef FETCH_INT_EN
        S_IVEC: begin
          r_pc    <= i_data;
          r_state <= S_RUN;
        end
`endif
        default: r_state <= S_RVEC;
      endcase
    end
  end

`ifdef FETCH_INT_EN
  logic              r_pend;
  logic              r_int_req_d;
  logic              r_int_ack;
  logic [DATA_W-1:0] r_ret_pc;
  logic              w_int_rise;

  assign w_int_rise = int_req & ~r_int_req_d;
  assign w_int_take = (r_state == S_RUN) & r_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend      <= 1'b0;
      r_int_req_d <= 1'b0;
      r_int_ack   <= 1'b0;
      r_ret_pc    <= '0;
    end else begin
      r_int_req_d <= int_req;
      r_int_ack   <= 1'b0;
      if (r_state == S_RUN && !redirect && !stall && r_pend)
        r_ret_pc <= r_pc;
      // A redirect during the vector load keeps the flag so entry is retried.
      if (r_state == S_IVEC && !redirect && !stall) begin
        r_int_ack <= 1'b1;
        r_pend    <= 1'b0;
      end
      if (w_int_rise && r_state != S_RVEC)
        r_pend <= 1'b1;
    end
  end

  assign int_ack = r_int_ack;
  assign ret_pc  = r_ret_pc;
`else
  logic w_unused_int_req;
  assign w_unused_int_req = int_req;
  assign w_int_take       = 1'b0;
  assign int_ack          = 1'b0;
  assign ret_pc           = '0;
`endif

  assign ir       = r_ir;
  assign imm      = r_imm;
  assign ir_valid = r_ir_valid;
  assign ir_long  = r_ir_long;
  assign pc_out   = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters, DATA_W=8).
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic       int_req;
  logic [7:0] i_data;
  logic [7:0] i_addr;
  logic [7:0] ir;
  logic [7:0] imm;
  logic       ir_valid;
  logic       ir_long;
  logic [7:0] pc_out;
  logic       int_ack;
  logic [7:0] ret_pc;

  logic [7:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  assign i_data = mem[i_addr];

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .int_req(int_req), .i_data(i_data),
    .i_addr(i_addr), .ir(ir), .imm(imm), .ir_valid(ir_valid), .ir_long(ir_long),
    .pc_out(pc_out), .int_ack(int_ack), .ret_pc(ret_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t pc=%h i_addr=%h ir=%h imm=%h valid=%b long=%b ack=%b ret=%h",
             $time, pc_out, i_addr, ir, imm, ir_valid, ir_long, int_ack, ret_pc);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc_out); end
    checks++; if (ir_valid !== 1'b0 || ir_long !== 1'b0 || int_ack !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b%b want 000", ir_valid, ir_long, int_ack); end
    checks++; if (ir !== 8'h00 || imm !== 8'h00 || ret_pc !== 8'h00) begin errors++; $display("FAIL reset_regs: got %h %h %h want 00 00 00", ir, imm, ret_pc); end
    checks++; if (i_addr !== 8'h00) begin errors++; $display("FAIL reset_iaddr: got %h want 00", i_addr); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (pc_out !== 8'h10 || ir_valid !== 1'b0) begin errors++; $display("FAIL rvec_load: got pc=%h v=%b want 10 0", pc_out, ir_valid); end
    tick();
    checks++; if (ir !== 8'h05 || ir_valid !== 1'b1 || pc_out !== 8'h11) begin errors++; $display("FAIL first_fetch: got ir=%h v=%b pc=%h want 05 1 11", ir, ir_valid, pc_out); end
    tick();
    checks++; if (ir !== 8'h06 || ir_valid !== 1'b1 || ir_long !== 1'b0 || pc_out !== 8'h12) begin errors++; $display("FAIL second_fetch: got ir=%h v=%b l=%b pc=%h want 06 1 0 12", ir, ir_valid, ir_long, pc_out); end
  endtask

  task automatic test_long();
    tick();
    checks++; if (ir_valid !== 1'b0 || pc_out !== 8'h13) begin errors++; $display("FAIL long_first: got v=%b pc=%h want 0 13", ir_valid, pc_out); end
    tick();
    checks++; if (ir !== 8'hC3 || imm !== 8'h7A || ir_long !== 1'b1 || ir_valid !== 1'b1 || pc_out !== 8'h14) begin errors++; $display("FAIL long_issue: got ir=%h imm=%h l=%b v=%b pc=%h want C3 7A 1 1 14", ir, imm, ir_long, ir_valid, pc_out); end
  endtask

  task automatic test_stall();
    tick();
    checks++; if (ir !== 8'h07 || ir_long !== 1'b0 || pc_out !== 8'h15) begin errors++; $display("FAIL pre_stall: got ir=%h l=%b pc=%h want 07 0 15", ir, ir_long, pc_out); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ir !== 8'h07 || ir_valid !== 1'b1 || pc_out !== 8'h15 || i_addr !== 8'h15) begin errors++; $display("FAIL stall_hold%0d: got ir=%h v=%b pc=%h a=%h want 07 1 15 15", i, ir, ir_valid, pc_out, i_addr); end
    end
    stall = 1'b0;
    tick();
    checks++; if (ir !== 8'h08 || ir_valid !== 1'b1 || pc_out !== 8'h16) begin errors++; $display("FAIL stall_resume: got ir=%h v=%b pc=%h want 08 1 16", ir, ir_valid, pc_out); end
  endtask

  task automatic test_redirect();
    tick();
    checks++; if (ir_valid !== 1'b0 || pc_out !== 8'h17) begin errors++; $display("FAIL redir_setup: got v=%b pc=%h want 0 17", ir_valid, pc_out); end
    redirect = 1'b1; redirect_addr = 8'h40; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    checks++; if (pc_out !== 8'h40 || ir_valid !== 1'b0) begin errors++; $display("FAIL redir_imm: got pc=%h v=%b want 40 0", pc_out, ir_valid); end
    tick();
    checks++; if (ir !== 8'h09 || ir_long !== 1'b0 || ir_valid !== 1'b1 || pc_out !== 8'h41) begin errors++; $display("FAIL redir_drop: got ir=%h l=%b v=%b pc=%h want 09 0 1 41", ir, ir_long, ir_valid, pc_out); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_addr = 8'hFF;
    tick();
    redirect = 1'b0;
    checks++; if (pc_out !== 8'hFF) begin errors++; $display("FAIL wrap_redir: got pc=%h want FF", pc_out); end
    tick();
    checks++; if (ir !== 8'h0B || ir_valid !== 1'b1 || pc_out !== 8'h00) begin errors++; $display("FAIL wrap_fetch: got ir=%h v=%b pc=%h want 0B 1 00", ir, ir_valid, pc_out); end
  endtask

  task automatic test_interrupt();
    redirect = 1'b1; redirect_addr = 8'h23; int_req = 1'b1;
    tick();
    redirect = 1'b0;
    checks++; if (pc_out !== 8'h23 || int_ack !== 1'b0) begin errors++; $display("FAIL int_setup: got pc=%h ack=%b want 23 0", pc_out, int_ack); end
`ifdef FETCH_INT_EN
    tick();
    checks++; if (ret_pc !== 8'h23 || ir_valid !== 1'b0 || int_ack !== 1'b0 || i_addr !== 8'h01) begin errors++; $display("FAIL int_entry: got ret=%h v=%b ack=%b a=%h want 23 0 0 01", ret_pc, ir_valid, int_ack, i_addr); end
    tick();
    checks++; if (pc_out !== 8'h80 || int_ack !== 1'b1) begin errors++; $display("FAIL int_vec: got pc=%h ack=%b want 80 1", pc_out, int_ack); end
    tick();
    checks++; if (int_ack !== 1'b0 || ir !== 8'h0E || ir_valid !== 1'b1 || pc_out !== 8'h81) begin errors++; $display("FAIL isr_fetch: got ack=%b ir=%h v=%b pc=%h want 0 0E 1 81", int_ack, ir, ir_valid, pc_out); end
    tick(); tick();
    checks++; if (int_ack !== 1'b0 || pc_out !== 8'h83 || ret_pc !== 8'h23) begin errors++; $display("FAIL int_level: got ack=%b pc=%h ret=%h want 0 83 23", int_ack, pc_out, ret_pc); end
`else
    tick();
    checks++; if (ir !== 8'h0C || ir_valid !== 1'b1 || pc_out !== 8'h24 || int_ack !== 1'b0) begin errors++; $display("FAIL noint_fetch: got ir=%h v=%b pc=%h ack=%b want 0C 1 24 0", ir, ir_valid, pc_out, int_ack); end
    int_req = 1'b0;
    tick();
    int_req = 1'b1;
    tick();
    checks++; if (ir !== 8'h0F || pc_out !== 8'h26 || int_ack !== 1'b0 || ret_pc !== 8'h00) begin errors++; $display("FAIL noint_toggle: got ir=%h pc=%h ack=%b ret=%h want 0F 26 0 00", ir, pc_out, int_ack, ret_pc); end
`endif
    int_req = 1'b0;
  endtask

  task automatic test_async_reset();
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pc_out !== 8'h00 || ir_valid !== 1'b0 || ir !== 8'h00 || i_addr !== 8'h00) begin errors++; $display("FAIL async_rst: got pc=%h v=%b ir=%h a=%h want 00 0 00 00", pc_out, ir_valid, ir, i_addr); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (pc_out !== 8'h10 || ir_valid !== 1'b0) begin errors++; $display("FAIL restart: got pc=%h v=%b want 10 0", pc_out, ir_valid); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h80;
    mem[8'h10] = 8'h05; mem[8'h11] = 8'h06; mem[8'h12] = 8'hC3; mem[8'h13] = 8'h7A;
    mem[8'h14] = 8'h07; mem[8'h15] = 8'h08; mem[8'h16] = 8'hC4; mem[8'h17] = 8'h55;
    mem[8'h40] = 8'h09; mem[8'hFF] = 8'h0B;
    mem[8'h23] = 8'h0C; mem[8'h24] = 8'h0D; mem[8'h25] = 8'h0F; mem[8'h80] = 8'h0E;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = 8'h00; int_req = 1'b0;
    test_reset();
    test_long();
    test_stall();
    test_redirect();
    test_wrap();
    test_interrupt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
